// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encoding, opcode constants and the 1149.1 next-state function.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUDR = 4'h3,
        SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
        EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUIR = 4'hB,
        RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
    } tap_state_e;

    // Truncated to IR_WIDTH at the point of use; -1 gives the all-ones BYPASS code.
    localparam int OPC_IDCODE = 1;
    localparam int OPC_BYPASS = -1;
    localparam int OPC_USER   = 8;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR   : RTI;
            RTI:     tap_next = tms ? SELDR : RTI;
            SELDR:   tap_next = tms ? SELIR : CAPDR;
            CAPDR:   tap_next = tms ? EX1DR : SHDR;
            SHDR:    tap_next = tms ? EX1DR : SHDR;
            EX1DR:   tap_next = tms ? UPDDR : PAUDR;
            PAUDR:   tap_next = tms ? EX2DR : PAUDR;
            EX2DR:   tap_next = tms ? UPDDR : SHDR;
            UPDDR:   tap_next = tms ? SELDR : RTI;
            SELIR:   tap_next = tms ? TLR   : CAPIR;
            CAPIR:   tap_next = tms ? EX1IR : SHIR;
            SHIR:    tap_next = tms ? EX1IR : SHIR;
            EX1IR:   tap_next = tms ? UPDIR : PAUIR;
            PAUIR:   tap_next = tms ? EX2IR : PAUIR;
            EX2IR:   tap_next = tms ? UPDIR : SHIR;
            UPDIR:   tap_next = tms ? SELDR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller, stepped on each sampled TCK rise; trst forces TLR.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_step,
    input  logic       i_tms,
    input  logic       i_trst,
    output tap_state_e o_state,
    output logic       o_tlr
);

    tap_state_e r_state, w_next;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_state <= TLR;
        else         r_state <= w_next;

    always_comb w_next = i_trst ? TLR : i_step ? tap_next(r_state, i_tms) : r_state;

    always_comb begin
        o_state = r_state;
        o_tlr   = r_state == TLR;
    end

endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: oversampled JTAG TAP target with IR, IDCODE and BYPASS registers.
// Define JTAG_TAP_USER_DR_EN to add the USER data register.
module jtag_tap_responder
    import jtag_tap_pkg::*;
#(
    parameter int          IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0DB3,
    parameter int          USER_DR_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     jtag_tck_i,
    input  logic                     jtag_tms_i,
    input  logic                     jtag_tdi_i,
    input  logic                     jtag_trst_i,
    output logic                     jtag_tdo_o,
    output tap_state_e               tap_state_o,
    output logic [IR_WIDTH-1:0]      ir_o,
    output logic                     tlr_o,
    output logic [USER_DR_WIDTH-1:0] user_dr_o,
    output logic                     user_update_o
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    logic                r_tck_q, r_tck_prev, r_tms_q, r_tdi_q, r_trst_q;
    logic                w_rise, w_fall, w_dr_lsb, w_sel_id;
    logic [IR_WIDTH-1:0] r_ir_sr, r_ir;
    logic [31:0]         r_id_sr;
    logic                r_bypass, r_tdo;
    tap_state_e          w_state;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) {r_tck_q, r_tck_prev, r_tms_q, r_tdi_q, r_trst_q} <= '0;
        else         {r_tck_q, r_tck_prev, r_tms_q, r_tdi_q, r_trst_q} <= {jtag_tck_i, r_tck_q, jtag_tms_i, jtag_tdi_i, jtag_trst_i};

    assign w_rise   = r_tck_q & ~r_tck_prev;
    assign w_fall   = ~r_tck_q & r_tck_prev;
    assign w_sel_id = r_ir == IR_IDCODE;

    jtag_tap_fsm u_fsm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_step  (w_rise),
        .i_tms   (r_tms_q),
        .i_trst  (r_trst_q),
        .o_state (w_state),
        .o_tlr   (tlr_o)
    );

    // Actions key off the state held before this TCK rise moves the FSM on.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_ir_sr  <= '0;
            r_ir     <= IR_IDCODE;
            r_id_sr  <= '0;
            r_bypass <= 1'b0;
            r_tdo    <= 1'b0;
        end else if (r_trst_q) begin
            r_ir     <= IR_IDCODE;
            r_tdo    <= 1'b0;
        end else if (w_rise) begin
            r_ir_sr  <= w_state == CAPIR ? IR_CAPTURE : w_state == SHIR ? {r_tdi_q, r_ir_sr[IR_WIDTH-1:1]} : r_ir_sr;
            r_ir     <= w_state == UPDIR ? r_ir_sr : r_ir;
            r_id_sr  <= w_state == CAPDR ? IDCODE_VALUE : w_state == SHDR ? {r_tdi_q, r_id_sr[31:1]} : r_id_sr;
            r_bypass <= w_state == CAPDR ? 1'b0 : w_state == SHDR ? r_tdi_q : r_bypass;
        end else if (w_fall) begin
            r_tdo    <= w_state == SHIR ? r_ir_sr[0] : w_state == SHDR ? w_dr_lsb : r_tdo;
        end

`ifdef JTAG_TAP_USER_DR_EN
    localparam logic [IR_WIDTH-1:0] IR_USER = IR_WIDTH'(OPC_USER);

    logic                     w_sel_user, w_act;
    logic [USER_DR_WIDTH-1:0] r_user_sr, r_user_dr;
    logic                     r_user_upd;

    assign w_sel_user = r_ir == IR_USER;
    assign w_act      = w_rise & ~r_trst_q & w_sel_user;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_user_sr  <= '0;
            r_user_dr  <= '0;
            r_user_upd <= 1'b0;
        end else begin
            r_user_sr  <= !w_act ? r_user_sr : w_state == CAPDR ? r_user_dr :
                          w_state == SHDR ? {r_tdi_q, r_user_sr[USER_DR_WIDTH-1:1]} : r_user_sr;
            r_user_dr  <= w_act && w_state == UPDDR ? r_user_sr : r_user_dr;
            r_user_upd <= w_act && w_state == UPDDR;
        end

    always_comb w_dr_lsb = w_sel_id ? r_id_sr[0] : w_sel_user ? r_user_sr[0] : r_bypass;

    assign user_dr_o     = r_user_dr;
    assign user_update_o = r_user_upd;
`else
    always_comb w_dr_lsb = w_sel_id ? r_id_sr[0] : r_bypass;

    assign user_dr_o     = '0;
    assign user_update_o = 1'b0;
`endif

    assign jtag_tdo_o  = r_tdo;
    assign tap_state_o = w_state;
    assign ir_o        = r_ir;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed bit-bang sequences against the TAP responder.
// Define JTAG_TAP_USER_DR_EN to exercise the USER data register.
module tb_jtag_tap_responder;
    import jtag_tap_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0, trst = 1'b0;
    logic        tdo, tlr, upd;
    tap_state_e  state;
    logic [4:0]  ir;
    logic [31:0] udr, d;
    int          n_chk = 0, n_fail = 0, n_pulse = 0;

    jtag_tap_responder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .jtag_tck_i    (tck),
        .jtag_tms_i    (tms),
        .jtag_tdi_i    (tdi),
        .jtag_trst_i   (trst),
        .jtag_tdo_o    (tdo),
        .tap_state_o   (state),
        .ir_o          (ir),
        .tlr_o         (tlr),
        .user_dr_o     (udr),
        .user_update_o (upd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (upd) n_pulse++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic di);
        tms = m;
        tdi = di;
        tck = 1'b1;
        clk_n(4);
        tck = 1'b0;
        clk_n(4);
    endtask

    // Starts in Shift with bit 0 already on TDO; leaves through Update to Run-Test/Idle.
    task automatic shift_upd(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout    = '0;
        dout[0] = tdo;
        for (int i = 1; i < n; i++) begin
            pulse(1'b0, din[i-1]);
            dout[i] = tdo;
        end
        pulse(1'b1, din[n-1]);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    task automatic to_shift_dr();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    task automatic to_shift_ir();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    initial begin
        clk_n(3);
        chk("reset_state", state, TLR);
        chk("reset_tlr",   tlr,   1'b1);
        chk("reset_ir",    ir,    5'h01);
        chk("reset_tdo",   tdo,   1'b0);
        chk("reset_udr",   udr,   32'h0);
        rst_n = 1'b1;
        clk_n(2);

        repeat (5) pulse(1'b1, 1'b0);
        chk("tms5_tlr", state, TLR);
        pulse(1'b0, 1'b0);
        chk("rti", state, RTI);
        to_shift_dr();
        chk("shift_dr_state", state, SHDR);
        shift_upd(32, 32'h0, d);
        chk("idcode", d, 32'h1000_0DB3);
        chk("idle_after_dr", state, RTI);

        to_shift_ir();
        shift_upd(5, 32'h1F, d);
        chk("ir_capture", d[4:0], 5'h01);
        chk("ir_bypass", ir, 5'h1F);
        to_shift_dr();
        shift_upd(4, 32'hD, d);
        chk("bypass_delay", d[3:0], 4'hA);

        to_shift_ir();
        shift_upd(5, 32'h0A, d);
        chk("ir_capture2", d[1:0], 2'b01);
        chk("ir_undef", ir, 5'h0A);
        to_shift_dr();
        shift_upd(3, 32'h3, d);
        chk("undef_bypass", d[2:0], 3'h6);

        to_shift_ir();
        shift_upd(5, 32'h08, d);
        chk("ir_user", ir, 5'h08);
        n_pulse = 0;
`ifdef JTAG_TAP_USER_DR_EN
        to_shift_dr();
        shift_upd(32, 32'hCAFE_F00D, d);
        chk("user_capture0", d, 32'h0);
        chk("user_dr", udr, 32'hCAFE_F00D);
        chk("user_pulses", n_pulse, 1);
        to_shift_dr();
        shift_upd(32, 32'h0, d);
        chk("user_readback", d, 32'hCAFE_F00D);
`else
        to_shift_dr();
        shift_upd(3, 32'h3, d);
        chk("user_as_bypass", d[2:0], 3'h6);
        chk("user_dr_tied", udr, 32'h0);
        chk("user_no_pulse", n_pulse, 0);
`endif

        to_shift_ir();
        shift_upd(5, 32'h0A, d);
        to_shift_dr();
        pulse(1'b0, 1'b1);
        chk("pre_trst_tdo", tdo, 1'b1);
        trst = 1'b1;
        clk_n(2);
        chk("trst_state", state, TLR);
        chk("trst_ir",    ir,    5'h01);
        chk("trst_tdo",   tdo,   1'b0);
        chk("trst_tlr",   tlr,   1'b1);
        trst = 1'b0;
        clk_n(2);

        pulse(1'b0, 1'b0);
        to_shift_ir();
        chk("pre_rst_state", state, SHIR);
        chk("pre_rst_tdo",   tdo,   1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_state", state, TLR);
        chk("rst_tlr",   tlr,   1'b1);
        chk("rst_ir",    ir,    5'h01);
        chk("rst_tdo",   tdo,   1'b0);
        chk("rst_udr",   udr,   32'h0);
        chk("rst_upd",   upd,   1'b0);
        clk_n(2);
        rst_n = 1'b1;
        pulse(1'b0, 1'b0);
        chk("post_rst_rti", state, RTI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
